// File: rtl/weight_update.sv
// Sequential backward-pass weight/bias update for one neuron, one element per cycle.
// Define WEIGHT_UPDATE_SAT_EN to saturate results instead of wrapping them.
`ifndef N
`define N 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module weight_update_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 18,
    parameter int LR_SHIFT   = 4
) (
    input  logic signed [ACC_WIDTH-1:0]  delta,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic        [DATA_WIDTH-1:0] y
);
    localparam int GW = ACC_WIDTH + DATA_WIDTH;
    localparam int DW = GW + 1;

    logic signed [GW-1:0] d_ext, x_ext, grad, step;
    logic signed [DW-1:0] diff;

    assign d_ext = GW'(delta);
    assign x_ext = GW'(x);
    assign grad  = d_ext * x_ext;
    assign step  = grad >>> LR_SHIFT;
    assign diff  = DW'(w) - DW'(step);

`ifdef WEIGHT_UPDATE_SAT_EN
    // In range only when every bit above the result sign matches it.
    logic ovf;
    assign ovf = !((&diff[DW-1:DATA_WIDTH-1]) || !(|diff[DW-1:DATA_WIDTH-1]));
    always_comb begin
        y = diff[DATA_WIDTH-1:0];
        if (ovf)
            y = diff[DW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    logic unused_hi;
    assign unused_hi = ^diff[DW-1:DATA_WIDTH];
    assign y = diff[DATA_WIDTH-1:0];
`endif
endmodule

module weight_update #(
    parameter int N          = `N,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = DATA_WIDTH*2 + $clog2(N),
    parameter int LR_SHIFT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DATA_WIDTH-1:0]   x,
    input  logic [N*DATA_WIDTH-1:0]   w,
    input  logic [DATA_WIDTH-1:0]     b,
    input  logic [ACC_WIDTH-1:0]      delta,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N*DATA_WIDTH-1:0]   w_new,
    output logic [DATA_WIDTH-1:0]     b_new,
    output logic                      busy
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, UPDATE, BIAS, DONE} state_t;
    state_t state, state_nx;

    logic [N-1:0][DATA_WIDTH-1:0] x_q, w_q, w_new_q;
    logic [DATA_WIDTH-1:0]        b_q, b_new_q;
    logic [ACC_WIDTH-1:0]         d_q;
    logic [IW-1:0]                idx;
    logic                         last;

    logic [DATA_WIDTH-1:0] op_x, op_w, lane_y;

    assign last = (idx == IW'(N-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (in_valid)  state_nx = UPDATE;
            UPDATE: if (last)      state_nx = BIAS;
            BIAS:                  state_nx = DONE;
            DONE:   if (out_ready) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // The bias step is the weight step with x = 1, so one lane serves both.
    always_comb begin
        op_x = x_q[idx];
        op_w = w_q[idx];
        if (state == BIAS) begin
            op_x = DATA_WIDTH'(1);
            op_w = b_q;
        end
    end

    weight_update_lane #(
        .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .LR_SHIFT(LR_SHIFT)
    ) u_lane (
        .delta (d_q),
        .x     (op_x),
        .w     (op_w),
        .y     (lane_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            idx     <= '0;
            w_new_q <= '0;
            b_new_q <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_q <= x;
                    w_q <= w;
                    b_q <= b;
                    d_q <= delta;
                    idx <= '0;
                end
                UPDATE: begin
                    w_new_q[idx] <= lane_y;
                    if (!last) idx <= idx + IW'(1);
                end
                BIAS:    b_new_q <= lane_y;
                default: ;
            endcase
        end
    end

    assign w_new = w_new_q;
    assign b_new = b_new_q;
endmodule

// File: tb/tb_weight_update.sv
// Scoreboard bench for weight_update (N=4, DATA_WIDTH=8, LR_SHIFT=4).
module tb_weight_update;
    localparam int N = 4, DW = 8, AW = 18, LR = 4;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
    logic [N*DW-1:0] x = '0, w = '0, w_new;
    logic [DW-1:0]   b = '0, b_new;
    logic [AW-1:0]   delta = '0;

    int checks = 0, errors = 0;
    logic [N*DW+DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    weight_update #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .LR_SHIFT(LR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .w(w), .b(b), .delta(delta), .out_valid(out_valid),
        .out_ready(out_ready), .w_new(w_new), .b_new(b_new), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fit_m(input longint d);
`ifdef WEIGHT_UPDATE_SAT_EN
        if (d > 127)  d = 127;
        if (d < -128) d = -128;
`endif
        return d[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] upd_m(input logic signed [DW-1:0] xi,
                                            input logic signed [DW-1:0] wi,
                                            input logic signed [AW-1:0] d);
        longint g, s, wl;
        g  = longint'(d) * longint'(xi);
        s  = g >>> LR;
        wl = wi;
        return fit_m(wl - s);
    endfunction

    // Output side of the scoreboard: a result is consumed on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
            else begin
                logic [N*DW+DW-1:0] e;
                e = sb_q.pop_front();
                chk("sb_w_new", 64'(w_new), 64'(e[N*DW+DW-1:DW]));
                chk("sb_b_new", 64'(b_new), 64'(e[DW-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input logic [N*DW-1:0] xv, input logic [N*DW-1:0] wv,
                         input logic [DW-1:0] bv, input logic [AW-1:0] dv,
                         input logic [N*DW-1:0] ew, input logic [DW-1:0] eb,
                         input int hold);
        int n;
        wait_ready();
        x = xv; w = wv; b = bv; delta = dv;
        in_valid = 1; out_ready = (hold == 0);
        sb_q.push_back({ew, eb});
        tick();
        in_valid = 0;
        x = ~xv; w = ~wv; b = ~bv; delta = ~dv;   // must not disturb the latched operands
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("latency", 64'(n), 64'(N+1));
        chk("done_w_new", 64'(w_new), 64'(ew));
        chk("done_b_new", 64'(b_new), 64'(eb));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1;
            tick();
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_w_new", 64'(w_new), 64'(ew));
            chk("bp_b_new", 64'(b_new), 64'(eb));
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_w_hold", 64'(w_new), 64'(ew));
    endtask

    initial begin
        logic [N*DW-1:0] xr, wr, ew;
        logic [DW-1:0]   br, eb;
        logic [AW-1:0]   dr;

        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_w_new", 64'(w_new), 64'd0);
        chk("rst_b_new", 64'(b_new), 64'd0);
        tick(); rst_n = 1; tick();

        // basic, negative delta, floor rounding
        do_op({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd10}}, 8'd5, 18'd16,
              {8'd6, 8'd7, 8'd8, 8'd9}, 8'd4, 0);
        do_op({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd10}}, 8'd5, -18'sd32,
              {8'd18, 8'd16, 8'd14, 8'd12}, 8'd7, 0);
        do_op({24'd0, 8'd1}, '0, 8'd0, -18'sd1, {24'd0, 8'd1}, 8'd1, 0);

        // overflow on element 0; bias = 0 - (100 >>> 4) = -6
`ifdef WEIGHT_UPDATE_SAT_EN
        do_op({24'd0, 8'd100}, {24'd0, 8'd127}, 8'd0, 18'd100, {24'd0, 8'h80}, 8'hFA, 0);
`else
        do_op({24'd0, 8'd100}, {24'd0, 8'd127}, 8'd0, 18'd100, {24'd0, 8'd14}, 8'hFA, 0);
`endif

        // backpressure for 5 cycles in DONE
        do_op({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd10}}, 8'd5, 18'd16,
              {8'd6, 8'd7, 8'd8, 8'd9}, 8'd4, 5);

        // random operands against the model
        for (int t = 0; t < 8; t++) begin
            xr = $urandom; wr = $urandom; br = 8'($urandom); dr = 18'($urandom);
            if (t == 0) dr = 18'h1FFFF;
            if (t == 1) dr = 18'h20000;
            for (int i = 0; i < N; i++)
                ew[i*DW +: DW] = upd_m(xr[i*DW +: DW], wr[i*DW +: DW], dr);
            eb = upd_m(8'd1, br, dr);
            do_op(xr, wr, br, dr, ew, eb, t % 3);
        end

        // reset while idx == 2
        wait_ready();
        x = {8'd4, 8'd3, 8'd2, 8'd1}; w = {4{8'd10}}; b = 8'd5; delta = 18'd16;
        in_valid = 1; out_ready = 1;
        tick();
        in_valid = 0;
        tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_w_new", 64'(w_new), 64'd0);
        chk("mid_rst_b_new", 64'(b_new), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick(); rst_n = 1; tick();
        do_op({8'd4, 8'd3, 8'd2, 8'd1}, {4{8'd10}}, 8'd5, -18'sd32,
              {8'd18, 8'd16, 8'd14, 8'd12}, 8'd7, 0);

        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
